// File: rtl/snake_pkg.sv
// snake_pkg: shared directions, state encoding, screen defaults and cell type for the snake engine
package snake_pkg;
   localparam int XSCREEN_DEF = 160;
   localparam int YSCREEN_DEF = 120;
   localparam int CELL_DEF    = 4;
   localparam logic [1:0] DIR_R = 2'd0;
   localparam logic [1:0] DIR_L = 2'd1;
   localparam logic [1:0] DIR_D = 2'd2;
   localparam logic [1:0] DIR_U = 2'd3;
   localparam logic [2:0] S_INIT  = 3'd0;
   localparam logic [2:0] S_IDLE  = 3'd1;
   localparam logic [2:0] S_CHECK = 3'd2;
   localparam logic [2:0] S_ERASE = 3'd3;
   localparam logic [2:0] S_DRAW  = 3'd4;
   localparam logic [2:0] S_DEAD  = 3'd5;
   typedef struct packed {
      logic [7:0] x;
      logic [6:0] y;
   } cell_t;
   // R<->L and D<->U differ only in bit 0
   function automatic logic [1:0] reverse_dir(input logic [1:0] d);
      return d ^ 2'b01;
   endfunction
endpackage

// File: rtl/snake_cell_painter.sv
// snake_cell_painter: scans one CELL x CELL square (x fastest) from a latched base, done on the last pixel
module snake_cell_painter
   import snake_pkg::*;
#(
   parameter int CELL    = CELL_DEF,
   parameter int COLOR_W = 9
) (
   input  logic               Clock,
   input  logic               Resetn,
   input  logic               start,
   input  cell_t              base,
   input  logic [COLOR_W-1:0] color,
   output logic [7:0]         VGA_x,
   output logic [6:0]         VGA_y,
   output logic [COLOR_W-1:0] VGA_color,
   output logic               VGA_write,
   output logic               done
);
   localparam int LW = $clog2(CELL);
   localparam int CW = 2 * LW;
   logic [CW-1:0]      cnt;
   cell_t              org;
   logic [COLOR_W-1:0] col;
   logic               active;
   // latch base/colour on start, then step the pixel counter until the square is covered
   always_ff @(posedge Clock) begin
      if (!Resetn) begin
         cnt    <= '0;
         org    <= '0;
         col    <= '0;
         active <= 1'b0;
      end else if (start) begin
         cnt    <= '0;
         org    <= base;
         col    <= color;
         active <= 1'b1;
      end else if (active) begin
         cnt    <= cnt + CW'(1);
         active <= !done;
      end
   end
   assign VGA_x     = org.x + 8'(cnt[LW-1:0]);
   assign VGA_y     = org.y + 7'(cnt[CW-1:LW]);
   assign VGA_color = col;
   assign VGA_write = active;
   assign done      = active && (&cnt);
endmodule

// File: rtl/snake_core.sv
// snake_core: circular-buffer snake with growth, collision and incremental redraw (optional SNAKE_WRAP_EN: wrap at screen edges)
module snake_core
   import snake_pkg::*;
#(
   parameter int XSCREEN  = XSCREEN_DEF,
   parameter int YSCREEN  = YSCREEN_DEF,
   parameter int CELL     = CELL_DEF,
   parameter int MAX_LEN  = 32,
   parameter int INIT_LEN = 4,
   parameter int COLOR_W  = 9
) (
   input  logic                       Clock,
   input  logic                       Resetn,
   input  logic                       tick,
   input  logic [1:0]                 dir_req,
   input  logic                       dir_valid,
   input  logic [7:0]                 food_x,
   input  logic [6:0]                 food_y,
   input  logic [COLOR_W-1:0]         new_color,
   output logic [7:0]                 VGA_x,
   output logic [6:0]                 VGA_y,
   output logic [COLOR_W-1:0]         VGA_color,
   output logic                       VGA_write,
   output logic                       ate,
   output logic                       dead,
   output logic [$clog2(MAX_LEN):0]   length,
   output logic                       busy
);
   localparam int PW = $clog2(MAX_LEN);
   localparam int LW = PW + 1;
   localparam logic [7:0] XMAX = 8'(XSCREEN - CELL);
   localparam logic [6:0] YMAX = 7'(YSCREEN - CELL);
   localparam logic [7:0] CX   = 8'(CELL);
   localparam logic [6:0] CY   = 7'(CELL);
   logic [2:0]         state;
   cell_t              body [MAX_LEN];
   logic [PW-1:0]      hp;
   logic [LW-1:0]      idx;
   logic [1:0]         dir, last_dir, nd;
   logic [COLOR_W-1:0] color, p_color;
   cell_t              nh, cand, head, tail, probe, p_base;
   logic               off_r, off_l, off_d, off_u, wall, hit, last_cmp, eat, grow;
   logic               p_start, p_done, push;
   // next direction, candidate head, collision probe and painter request
   always_comb begin
      nd       = dir_valid && dir_req != reverse_dir(last_dir) ? dir_req : dir;
      head     = body[hp];
      probe    = body[hp + idx[PW-1:0]];
      tail     = body[hp + PW'(length - LW'(1))];
      off_r    = nd == DIR_R && head.x >= XMAX;
      off_l    = nd == DIR_L && head.x == 8'd0;
      off_d    = nd == DIR_D && head.y >= YMAX;
      off_u    = nd == DIR_U && head.y == 7'd0;
      cand     = head;
      cand.x   = nd == DIR_R ? head.x + CX : nd == DIR_L ? head.x - CX : head.x;
      cand.y   = nd == DIR_D ? head.y + CY : nd == DIR_U ? head.y - CY : head.y;
`ifdef SNAKE_WRAP_EN
      cand.x   = off_r ? 8'd0 : off_l ? XMAX : cand.x;
      cand.y   = off_d ? 7'd0 : off_u ? YMAX : cand.y;
      wall     = 1'b0;
`else
      wall     = off_r | off_l | off_d | off_u;
`endif
      hit      = probe == nh;
      last_cmp = idx == length - LW'(2);
      eat      = nh.x == food_x && nh.y == food_y;
      grow     = eat && length != LW'(MAX_LEN);
      p_start  = state == S_INIT  ? !VGA_write :
                 state == S_CHECK ? last_cmp && !hit :
                 state == S_ERASE ? p_done : 1'b0;
      p_base   = state == S_INIT ? probe : (state == S_CHECK && !grow) ? tail : nh;
      p_color  = state == S_CHECK && !grow ? '0 : color;
      push     = (state == S_CHECK && last_cmp && !hit && grow) || (state == S_ERASE && p_done);
   end
   // body buffer: new head is written just below the head pointer
   always_ff @(posedge Clock) begin
      if (!Resetn) begin
         for (int i = 0; i < MAX_LEN; i++) begin
            body[i].x <= i < INIT_LEN ? 8'(XSCREEN / 2 - i * CELL) : 8'd0;
            body[i].y <= i < INIT_LEN ? 7'(YSCREEN / 2) : 7'd0;
         end
      end else if (push) begin
         body[hp - PW'(1)] <= nh;
      end
   end
   // game sequencing: init draw, step, collision scan, erase tail, draw head
   always_ff @(posedge Clock) begin
      if (!Resetn) begin
         state    <= S_INIT;
         hp       <= '0;
         idx      <= '0;
         dir      <= DIR_R;
         last_dir <= DIR_R;
         color    <= '1;
         length   <= LW'(INIT_LEN);
         ate      <= 1'b0;
         dead     <= 1'b0;
         nh       <= '0;
      end else begin
         ate <= 1'b0;
         dir <= nd;
         if (new_color != '0) color <= new_color;
         if (push) hp <= hp - PW'(1);
         case (state)
            S_INIT: if (p_done) begin
               idx <= idx + LW'(1);
               if (idx == length - LW'(1)) state <= S_IDLE;
            end
            S_IDLE: if (tick) begin
               last_dir <= nd;
               nh       <= cand;
               idx      <= '0;
               dead     <= wall;
               state    <= wall ? S_DEAD : S_CHECK;
            end
            S_CHECK: if (hit) begin
               dead  <= 1'b1;
               state <= S_DEAD;
            end else if (last_cmp) begin
               ate    <= eat;
               length <= grow ? length + LW'(1) : length;
               state  <= grow ? S_DRAW : S_ERASE;
            end else begin
               idx <= idx + LW'(1);
            end
            S_ERASE: if (p_done) state <= S_DRAW;
            S_DRAW:  if (p_done) state <= S_IDLE;
            default: ;
         endcase
      end
   end
   assign busy = state != S_IDLE && state != S_DEAD;
   snake_cell_painter #(.CELL(CELL), .COLOR_W(COLOR_W)) u_painter (
      .Clock     (Clock),
      .Resetn    (Resetn),
      .start     (p_start),
      .base      (p_base),
      .color     (p_color),
      .VGA_x     (VGA_x),
      .VGA_y     (VGA_y),
      .VGA_color (VGA_color),
      .VGA_write (VGA_write),
      .done      (p_done)
   );
endmodule

// File: tb/tb_snake_core.sv
// tb_snake_core: randomized + directed scoreboard bench for snake_core against a queue-based snake model
module tb_snake_core;
   localparam int MAX_LEN  = 32;
   localparam int INIT_LEN = 4;
   logic       clk = 1'b0, Resetn = 1'b0, tick = 1'b0, dir_valid = 1'b0;
   logic [1:0] dir_req = '0;
   logic [7:0] food_x = '0;
   logic [6:0] food_y = '0;
   logic [8:0] new_color = '0;
   logic [7:0] VGA_x;
   logic [6:0] VGA_y;
   logic [8:0] VGA_color;
   logic       VGA_write, ate, dead, busy;
   logic [5:0] length;
   int compared = 0, mismatched = 0;
   logic [23:0] expq[$];
   logic [23:0] e;
   bit  ignore_px = 1'b0;
   int  ate_seen = 0;
   int  mx[$], my[$];
   int  m_len, m_dir, m_last, m_color, m_ate = 0;
   bit  m_dead;

   snake_core #(.MAX_LEN(MAX_LEN), .INIT_LEN(INIT_LEN), .COLOR_W(9)) dut (
      .Clock(clk), .Resetn(Resetn), .tick(tick), .dir_req(dir_req), .dir_valid(dir_valid),
      .food_x(food_x), .food_y(food_y), .new_color(new_color), .VGA_x(VGA_x), .VGA_y(VGA_y),
      .VGA_color(VGA_color), .VGA_write(VGA_write), .ate(ate), .dead(dead), .length(length), .busy(busy)
   );

   always #5 clk = ~clk;

   always @(negedge clk) begin
      if (ate) ate_seen++;
      if (VGA_write && !ignore_px) begin
         compared++;
         if (expq.size() == 0) begin
            mismatched++;
            $display("FAIL pixel: unexpected write x=%0d y=%0d c=%h", VGA_x, VGA_y, VGA_color);
         end else begin
            e = expq.pop_front();
            if (e != {VGA_x, VGA_y, VGA_color}) begin
               mismatched++;
               $display("FAIL pixel: got x=%0d y=%0d c=%h expected x=%0d y=%0d c=%h",
                        VGA_x, VGA_y, VGA_color, e[23:16], e[15:9], e[8:0]);
            end
         end
      end
   end

   task automatic check(input string name, input int act, input int exp);
      compared++;
      if (act != exp) begin
         mismatched++;
         $display("FAIL %s: got %0d expected %0d", name, act, exp);
      end
   endtask

   task automatic push_cell(input int x, input int y, input int c);
      for (int yy = 0; yy < 4; yy++)
         for (int xx = 0; xx < 4; xx++)
            expq.push_back({8'(x + xx), 7'(y + yy), 9'(c)});
   endtask

   task automatic model_reset();
      mx.delete();
      my.delete();
      for (int i = 0; i < INIT_LEN; i++) begin
         mx.push_back(80 - 4 * i);
         my.push_back(60);
      end
      m_len = INIT_LEN; m_dir = 0; m_last = 0; m_color = 9'h1FF; m_dead = 1'b0;
      for (int i = 0; i < INIT_LEN; i++) push_cell(mx[i], my[i], m_color);
   endtask

   task automatic wait_idle(input string name);
      int n = 0;
      while (busy && n < 400) begin
         @(negedge clk);
         n++;
      end
      check(name, busy, 0);
   endtask

   task automatic do_reset(input bit midop);
      if (midop) ignore_px = 1'b1;
      @(negedge clk);
      Resetn = 1'b0;
      @(negedge clk);
      check("rst_write", VGA_write, 0);
      check("rst_x", VGA_x, 0);
      check("rst_dead", dead, 0);
      check("rst_ate", ate, 0);
      check("rst_len", length, INIT_LEN);
      check("rst_busy", busy, 1);
      expq.delete();
      ignore_px = 1'b0;
      model_reset();
      @(negedge clk);
      Resetn = 1'b1;
      @(negedge clk);
      wait_idle("init_timeout");
      check("init_len", length, INIT_LEN);
      check("init_pending", expq.size(), 0);
   endtask

   function automatic int rev(input int d);
      return d == 0 ? 1 : d == 1 ? 0 : d == 2 ? 3 : 2;
   endfunction

   // food_mode: 0 random cell, 1 on the next head, 2 fixed at (0,0)
   task automatic move(input int d, input bit dv, input int food_mode, input int nc);
      int nx, ny, fx, fy;
      bit out, hit, eat;
      if (dv && d != rev(m_last)) m_dir = d;
      nx = mx[0] + (m_dir == 0 ? 4 : m_dir == 1 ? -4 : 0);
      ny = my[0] + (m_dir == 2 ? 4 : m_dir == 3 ? -4 : 0);
      out = nx < 0 || nx > 156 || ny < 0 || ny > 116;
`ifdef SNAKE_WRAP_EN
      if (nx < 0) nx = 156;
      if (nx > 156) nx = 0;
      if (ny < 0) ny = 116;
      if (ny > 116) ny = 0;
      out = 1'b0;
`endif
      if (food_mode == 1 && !out) begin
         fx = nx; fy = ny;
      end else if (food_mode == 2) begin
         fx = 0; fy = 0;
      end else begin
         fx = 4 * $urandom_range(0, 39); fy = 4 * $urandom_range(0, 29);
      end
      if (nc != 0) m_color = nc;
      if (!m_dead) begin
         m_last = m_dir;
         hit = 1'b0;
         for (int i = 0; i <= m_len - 2; i++) if (mx[i] == nx && my[i] == ny) hit = 1'b1;
         if (out || hit) m_dead = 1'b1;
         else begin
            eat = nx == fx && ny == fy;
            if (eat) m_ate++;
            if (eat && m_len < MAX_LEN) m_len++;
            else begin
               push_cell(mx[m_len - 1], my[m_len - 1], 0);
               void'(mx.pop_back());
               void'(my.pop_back());
            end
            mx.push_front(nx);
            my.push_front(ny);
            push_cell(nx, ny, m_color);
         end
      end
      @(negedge clk);
      tick = 1'b1; dir_req = 2'(d); dir_valid = dv; new_color = 9'(nc);
      food_x = 8'(fx); food_y = 7'(fy);
      @(negedge clk);
      tick = 1'b0; dir_valid = 1'b0; new_color = '0;
      wait_idle("move_timeout");
      check("move_pending", expq.size(), 0);
      check("move_dead", dead, m_dead);
      check("move_len", length, m_len);
      check("move_ate", ate_seen, m_ate);
   endtask

   initial begin
      do_reset(1'b0);
      move(0, 1'b1, 2, 0);
      move(0, 1'b0, 1, 0);
      move(1, 1'b1, 2, 0);
      move(3, 1'b1, 2, 0);
      move(0, 1'b1, 2, 9'h0AA);
      for (int i = 0; i < 40 && !m_dead; i++) move(0, 1'b0, 2, 0);
      move(2, 1'b1, 2, 0);
      do_reset(1'b0);
      move(0, 1'b0, 1, 0);
      move(3, 1'b1, 2, 0);
      move(1, 1'b1, 2, 0);
      move(2, 1'b1, 2, 0);
      do_reset(1'b0);
      for (int i = 0; i < 16; i++) move(0, 1'b1, 1, 0);
      move(2, 1'b1, 1, 0);
      for (int i = 0; i < 20; i++) move(1, 1'b1, 1, 0);
      ignore_px = 1'b1;
      @(negedge clk);
      tick = 1'b1; food_x = '0; food_y = '0;
      @(negedge clk);
      tick = 1'b0;
      repeat (8) @(negedge clk);
      do_reset(1'b1);
      for (int ep = 0; ep < 5; ep++) begin
         if (ep != 0) do_reset(1'b0);
         for (int k = 0; k < 40 && !m_dead; k++)
            move($urandom_range(0, 3), 1'($urandom_range(0, 1)),
                 $urandom_range(0, 2) == 0 ? 1 : 0,
                 $urandom_range(0, 3) == 0 ? $urandom_range(1, 511) : 0);
      end
      $display("*** SUMMARY: %0d compared / %0d mismatched ***", compared, mismatched);
      $finish;
   end
endmodule
